// File: rtl/cmp_share_if.sv
// cmp_share_if: request/response channels between requesters and the shared compare arbiter
interface cmp_share_if #(
  parameter int NREQ = 4,
  parameter int W = 32
);
  localparam int IDW = $clog2(NREQ);
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [NREQ-1:0] req_signed;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic rsp_valid;
  logic rsp_ready;
  logic [IDW-1:0] rsp_id;
  logic rsp_less;
  logic rsp_equal;
  modport master (
    output req_valid, req_signed, req_a, req_b, rsp_ready,
    input req_ready, rsp_valid, rsp_id, rsp_less, rsp_equal
  );
  modport slave (
    input req_valid, req_signed, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_less, rsp_equal
  );
endinterface

// File: rtl/cmp_share_arbiter.sv
// cmp_share_arbiter: round-robin sharing of one subtract-based less/equal compare; `CMP_SIGNED_EN adds per-request signed compares
module cmp_share_arbiter #(
  parameter int NREQ = 4,
  parameter int W = 32
) (
  input logic clk,
  input logic rst_n,
  cmp_share_if.slave bus
);
  localparam int IDW = $clog2(NREQ);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state, state_nx;
  logic [IDW-1:0] ptr, g, id_q;
  logic found, can_accept, acc, less, equal, less_q, equal_q;
  logic [W-1:0] a, b;
  logic [W:0] diff;
  always_comb begin
    found = 1'b0;
    g = ptr;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && bus.req_valid[(int'(ptr) + k) % NREQ]) begin
        found = 1'b1;
        g = IDW'((int'(ptr) + k) % NREQ);
      end
    end
  end
  assign can_accept = (state == EMPTY) || bus.rsp_ready;
  assign acc = rst_n && can_accept && found;
  assign bus.req_ready = acc ? {{(NREQ-1){1'b0}}, 1'b1} << g : '0;
  assign a = bus.req_a[int'(g)*W +: W];
  assign b = bus.req_b[int'(g)*W +: W];
  assign diff = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
  assign equal = diff[W-1:0] == '0;
`ifdef CMP_SIGNED_EN
  logic ovf;
  assign ovf = (a[W-1] ^ b[W-1]) & (a[W-1] ^ diff[W-1]);
  assign less = bus.req_signed[g] ? diff[W-1] ^ ovf : ~diff[W];
`else
  logic unused_signed;
  assign unused_signed = ^bus.req_signed;
  assign less = ~diff[W];
`endif
  always_comb begin
    state_nx = acc ? FULL : (state == FULL && bus.rsp_ready) ? EMPTY : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      ptr <= IDW'(NREQ-1);
      id_q <= '0;
      less_q <= 1'b0;
      equal_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (acc) begin
        ptr <= g;
        id_q <= g;
        less_q <= less;
        equal_q <= equal;
      end
    end
  end
  assign bus.rsp_valid = state == FULL;
  assign bus.rsp_id = id_q;
  assign bus.rsp_less = less_q;
  assign bus.rsp_equal = equal_q;
endmodule

// File: tb/tb_cmp_share_arbiter.sv
// tb_cmp_share_arbiter: directed and random stimulus against a transaction-level model of the shared comparer
module tb_cmp_share_arbiter;
  localparam int NREQ = 4;
  localparam int W = 32;
  localparam int IDW = $clog2(NREQ);
`ifdef CMP_SIGNED_EN
  localparam bit SG_EN = 1'b1;
`else
  localparam bit SG_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  cmp_share_if #(.NREQ(NREQ), .W(W)) bus();
  cmp_share_arbiter #(.NREQ(NREQ), .W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int n_cmp = 0;
  int n_err = 0;
  logic [NREQ-1:0] v = '0;
  logic [NREQ-1:0] s = '0;
  logic rr = 1'b1;
  logic [W-1:0] a [NREQ];
  logic [W-1:0] b [NREQ];
  int m_ptr, m_id, m_g;
  bit m_valid, m_less, m_equal, m_acc;
  logic [NREQ-1:0] exp_ready;
  function automatic bit ref_less(logic [W-1:0] x, logic [W-1:0] y, bit sg);
    return (SG_EN && sg) ? ($signed(x) < $signed(y)) : (x < y);
  endfunction
  function automatic logic [W-1:0] rnd_op();
    int sel;
    sel = $urandom_range(0, 3);
    if (sel == 0) begin
      int c;
      logic [W-1:0] corner [4];
      corner[0] = '0; corner[1] = '1; corner[2] = 32'h8000_0000; corner[3] = 32'h7FFF_FFFF;
      c = $urandom_range(0, 3);
      return corner[c];
    end
    if (sel == 1) return W'($urandom_range(0, 7));
    return W'($urandom);
  endfunction
  task automatic drive();
    bus.req_valid = v;
    bus.req_signed = s;
    bus.rsp_ready = rr;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[i*W +: W] = a[i];
      bus.req_b[i*W +: W] = b[i];
    end
  endtask
  task automatic model_reset();
    m_valid = 0; m_id = 0; m_less = 0; m_equal = 0; m_ptr = NREQ - 1;
  endtask
  task automatic model_grant();
    m_acc = 0; m_g = 0; exp_ready = '0;
    if (rst_n && (!m_valid || rr))
      for (int k = 1; k <= NREQ; k++) begin
        automatic int i = (m_ptr + k) % NREQ;
        if (!m_acc && v[i]) begin m_acc = 1; m_g = i; end
      end
    if (m_acc) exp_ready[m_g] = 1'b1;
  endtask
  task automatic prep();
    drive();
    #1;
    model_grant();
  endtask
  task automatic tick();
    @(posedge clk);
    if (m_acc) begin
      m_valid = 1; m_id = m_g; m_ptr = m_g;
      m_less = ref_less(a[m_g], b[m_g], s[m_g]);
      m_equal = (a[m_g] == b[m_g]);
    end else if (m_valid && rr) m_valid = 0;
    #1;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_reset();
    v = '1; rr = 1'b1;
    prep();
    model_reset();
    n_cmp++;
    if (bus.req_ready !== '0 || bus.rsp_valid !== 1'b0 || bus.rsp_id !== '0 || bus.rsp_less !== 1'b0 || bus.rsp_equal !== 1'b0) begin
      n_err++;
      $display("FAIL reset: ready=%b v=%b id=%0d l=%b e=%b, want all zero", bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_less, bus.rsp_equal);
    end
    v = '0;
    drive();
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_single();
    logic [W-1:0] ta [2];
    logic [W-1:0] tb [2];
    bit tl [2];
    bit te [2];
    ta[0] = 5; tb[0] = 7; tl[0] = 1; te[0] = 0;
    ta[1] = 32'h1234; tb[1] = 32'h1234; tl[1] = 0; te[1] = 1;
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      v = 4'b0001; s = '0; rr = 1'b1; a[0] = ta[t]; b[0] = tb[t];
      prep();
      n_cmp++;
      if (bus.req_ready !== 4'b0001) begin
        n_err++;
        $display("FAIL single ready: got %b want 0001", bus.req_ready);
      end
      tick();
      n_cmp++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== '0 || bus.rsp_less !== tl[t] || bus.rsp_equal !== te[t] || m_less != tl[t]) begin
        n_err++;
        $display("FAIL single rsp%0d: got v=%b id=%0d l=%b e=%b want v=1 id=0 l=%b e=%b", t, bus.rsp_valid, bus.rsp_id, bus.rsp_less, bus.rsp_equal, tl[t], te[t]);
      end
    end
    @(negedge clk);
    v = '0;
    prep();
    tick();
  endtask
  task automatic test_signed();
    logic [W-1:0] ta [2];
    logic [W-1:0] tb [2];
    ta[0] = 32'hFFFF_FFFF; tb[0] = 32'h1;
    ta[1] = 32'h8000_0000; tb[1] = 32'h7FFF_FFFF;
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      v = 4'b0100; s = 4'b0100; rr = 1'b1; a[2] = ta[t]; b[2] = tb[t];
      prep();
      tick();
      n_cmp++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== IDW'(2) || bus.rsp_less !== SG_EN || bus.rsp_equal !== 1'b0) begin
        n_err++;
        $display("FAIL signed%0d: got v=%b id=%0d l=%b e=%b want v=1 id=2 l=%b e=0", t, bus.rsp_valid, bus.rsp_id, bus.rsp_less, bus.rsp_equal, SG_EN);
      end
    end
    @(negedge clk);
    v = '0; s = '0;
    prep();
    tick();
  endtask
  task automatic test_round_robin();
    int order [6] = '{0, 1, 2, 3, 0, 1};
    do_reset();
    for (int i = 0; i < NREQ; i++) begin a[i] = rnd_op(); b[i] = rnd_op(); end
    for (int t = 0; t < 10; t++) begin
      v = (t < 6) ? 4'b1111 : 4'b1010; rr = 1'b1;
      prep();
      n_cmp++;
      if (bus.req_ready !== exp_ready || (t < 6 && m_g != order[t])) begin
        n_err++;
        $display("FAIL rr grant%0d: got %b want %b", t, bus.req_ready, exp_ready);
      end
      tick();
      n_cmp++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== IDW'(m_id) || bus.rsp_less !== m_less || bus.rsp_equal !== m_equal) begin
        n_err++;
        $display("FAIL rr rsp%0d: got id=%0d l=%b e=%b want id=%0d l=%b e=%b", t, bus.rsp_id, bus.rsp_less, bus.rsp_equal, m_id, m_less, m_equal);
      end
      @(negedge clk);
    end
    v = '0;
    prep();
    tick();
  endtask
  task automatic test_backpressure();
    logic [IDW-1:0] hid;
    logic hl, he;
    @(negedge clk);
    v = 4'b1111; rr = 1'b1;
    prep();
    tick();
    hid = bus.rsp_id; hl = bus.rsp_less; he = bus.rsp_equal;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      rr = 1'b0;
      prep();
      n_cmp++;
      if (bus.req_ready !== '0) begin
        n_err++;
        $display("FAIL bp ready%0d: got %b want 0000", t, bus.req_ready);
      end
      tick();
      n_cmp++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== IDW'(m_id) || hid !== IDW'(m_id) || bus.rsp_less !== hl || bus.rsp_equal !== he) begin
        n_err++;
        $display("FAIL bp hold%0d: got v=%b id=%0d l=%b e=%b want v=1 id=%0d l=%b e=%b", t, bus.rsp_valid, bus.rsp_id, bus.rsp_less, bus.rsp_equal, m_id, m_less, m_equal);
      end
    end
    @(negedge clk);
    rr = 1'b1;
    prep();
    n_cmp++;
    if (bus.req_ready !== exp_ready || exp_ready == '0) begin
      n_err++;
      $display("FAIL bp release ready: got %b want %b", bus.req_ready, exp_ready);
    end
    tick();
    n_cmp++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== IDW'(m_id) || bus.rsp_less !== m_less || bus.rsp_equal !== m_equal) begin
      n_err++;
      $display("FAIL bp replace: got v=%b id=%0d want v=1 id=%0d", bus.rsp_valid, bus.rsp_id, m_id);
    end
  endtask
  task automatic test_drain();
    @(negedge clk);
    v = 4'b0001; rr = 1'b1;
    prep();
    tick();
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      v = '0;
      prep();
      tick();
      n_cmp++;
      if (bus.rsp_valid !== 1'b0 || m_valid) begin
        n_err++;
        $display("FAIL drain%0d: rsp_valid got %b want 0", t, bus.rsp_valid);
      end
    end
  endtask
  task automatic test_reset_mid();
    @(negedge clk);
    v = 4'b1111; rr = 1'b0;
    prep();
    tick();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_id !== '0 || bus.req_ready !== '0) begin
      n_err++;
      $display("FAIL reset mid: got v=%b id=%0d ready=%b want 0/0/0000", bus.rsp_valid, bus.rsp_id, bus.req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    v = 4'b1110; rr = 1'b1;
    prep();
    n_cmp++;
    if (bus.req_ready !== 4'b0010) begin
      n_err++;
      $display("FAIL reset mid grant: got %b want 0010", bus.req_ready);
    end
    tick();
    @(negedge clk);
    v = '0;
    prep();
    tick();
  endtask
  task automatic test_random();
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++)
        if (!v[i] || (m_acc && m_g == i)) begin
          v[i] = $urandom_range(0, 1);
          s[i] = $urandom_range(0, 1);
          a[i] = rnd_op();
          b[i] = ($urandom_range(0, 3) == 0) ? a[i] : rnd_op();
        end
      rr = ($urandom_range(0, 3) != 0);
      prep();
      n_cmp++;
      if (bus.req_ready !== exp_ready) begin
        n_err++;
        $display("FAIL rand ready%0d: got %b want %b", t, bus.req_ready, exp_ready);
      end
      tick();
      n_cmp++;
      if (bus.rsp_valid !== m_valid || bus.rsp_id !== IDW'(m_id) || bus.rsp_less !== m_less || bus.rsp_equal !== m_equal) begin
        n_err++;
        $display("FAIL rand rsp%0d: got v=%b id=%0d l=%b e=%b want v=%b id=%0d l=%b e=%b", t, bus.rsp_valid, bus.rsp_id, bus.rsp_less, bus.rsp_equal, m_valid, m_id, m_less, m_equal);
      end
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: run did not end within time limit");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < NREQ; i++) begin a[i] = '0; b[i] = '0; end
    m_acc = 0; m_g = 0;
    test_reset();
    test_single();
    test_signed();
    test_round_robin();
    test_backpressure();
    test_drain();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
